// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: holds the PLL in reset, qualifies lock, then releases
// downstream domain resets in order and re-runs on lock loss, timeout or restart.
module pll_reset_sequencer #(
    parameter int RST_HOLD_CYCLES     = 10,
    parameter int LOCK_STABLE_CYCLES  = 256,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int NUM_DOMAINS         = 3,
    parameter int DOMAIN_GAP_CYCLES   = 16
) (
    input  logic                   refclk,
    input  logic                   rst,
    input  logic                   pll_locked,
    input  logic                   restart_req,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   clocks_ready,
    output logic                   lock_lost,
    output logic                   timeout_err,
    output logic [7:0]             retry_count
);

    localparam int REL_LAST  = (NUM_DOMAINS - 1) * DOMAIN_GAP_CYCLES;
    localparam int HOLD_W    = $clog2(RST_HOLD_CYCLES) + 1;
    localparam int STABLE_W  = $clog2(LOCK_STABLE_CYCLES) + 1;
    localparam int TOUT_W    = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
    localparam int REL_W     = $clog2(REL_LAST) + 1;

    typedef enum logic [1:0] {
        S_RESET,
        S_WAIT_LOCK,
        S_RELEASE,
        S_RUN
    } state_t;

    state_t                   state, state_next;
    logic [HOLD_W-1:0]        hold_cnt, hold_next;
    logic [STABLE_W-1:0]      stable_cnt, stable_next;
    logic [TOUT_W-1:0]        tout_cnt, tout_next;
    logic [REL_W-1:0]         rel_cnt, rel_next;
    logic [NUM_DOMAINS-1:0]   domain_next;
    logic                     timeout_hit;
    logic                     loss_hit;
    logic [1:0]               sync_q;
    logic                     lk_s;

    assign lk_s = sync_q[1];

    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    // Restart overrides lock qualification, but a coincident timeout still reports.
    always_comb begin
        state_next  = state;
        hold_next   = hold_cnt;
        stable_next = stable_cnt;
        tout_next   = tout_cnt;
        rel_next    = rel_cnt;
        timeout_hit = 1'b0;
        loss_hit    = 1'b0;
        domain_next = '1;

        case (state)
            S_RESET: begin
                if (hold_cnt == HOLD_W'(RST_HOLD_CYCLES - 1)) begin
                    state_next = S_WAIT_LOCK;
                end else begin
                    hold_next = hold_cnt + HOLD_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                stable_next = lk_s ? stable_cnt + STABLE_W'(1) : '0;
                tout_next   = tout_cnt + TOUT_W'(1);
                if (stable_next == STABLE_W'(LOCK_STABLE_CYCLES)) begin
                    state_next = S_RELEASE;
                end else if (tout_next == TOUT_W'(LOCK_TIMEOUT_CYCLES)) begin
                    timeout_hit = 1'b1;
                    state_next  = S_RESET;
                end
                if (restart_req) begin
                    state_next = S_RESET;
                end
            end
            S_RELEASE: begin
                if (!lk_s) begin
                    loss_hit   = 1'b1;
                    state_next = S_RESET;
                end else if (rel_cnt == REL_W'(REL_LAST)) begin
                    state_next = S_RUN;
                end else begin
                    rel_next = rel_cnt + REL_W'(1);
                end
                if (restart_req) begin
                    state_next = S_RESET;
                end
            end
            S_RUN: begin
                if (!lk_s) begin
                    loss_hit   = 1'b1;
                    state_next = S_RESET;
                end
                if (restart_req) begin
                    state_next = S_RESET;
                end
            end
            default: state_next = S_RESET;
        endcase

        if (state_next != state) begin
            hold_next   = '0;
            stable_next = '0;
            tout_next   = '0;
            rel_next    = '0;
        end

        for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (state_next == S_RUN) begin
                domain_next[i] = 1'b0;
            end else if (state_next == S_RELEASE &&
                         int'(rel_next) >= i * DOMAIN_GAP_CYCLES) begin
                domain_next[i] = 1'b0;
            end
        end
    end

    // Outputs are registered from the state being entered, alongside the state.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state        <= S_RESET;
            hold_cnt     <= '0;
            stable_cnt   <= '0;
            tout_cnt     <= '0;
            rel_cnt      <= '0;
            pll_rst      <= 1'b1;
            domain_rst   <= '1;
            clocks_ready <= 1'b0;
            lock_lost    <= 1'b0;
            timeout_err  <= 1'b0;
            retry_count  <= 8'd0;
        end else begin
            state        <= state_next;
            hold_cnt     <= hold_next;
            stable_cnt   <= stable_next;
            tout_cnt     <= tout_next;
            rel_cnt      <= rel_next;
            pll_rst      <= (state_next == S_RESET);
            domain_rst   <= domain_next;
            clocks_ready <= (state_next == S_RUN);
            lock_lost    <= lock_lost | loss_hit;
            timeout_err  <= timeout_hit;
            if (timeout_hit && retry_count != 8'd255) begin
                retry_count <= retry_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios plus random lock/restart
// traffic, checked every cycle against a phase/elapsed-time reference model.
module tb_pll_reset_sequencer;

    localparam int HOLD   = 4;
    localparam int STABLE = 8;
    localparam int TOUT   = 100;
    localparam int ND     = 3;
    localparam int GAP    = 2;

    localparam int PH_RESET = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_REL   = 2;
    localparam int PH_RUN   = 3;

    logic          refclk = 1'b0;
    logic          rst = 1'b1;
    logic          pll_locked = 1'b0;
    logic          restart_req = 1'b0;
    logic          pll_rst;
    logic [ND-1:0] domain_rst;
    logic          clocks_ready;
    logic          lock_lost;
    logic          timeout_err;
    logic [7:0]    retry_count;

    int total_checks = 0;
    int pass_checks  = 0;
    int cyc          = 0;

    int m_phase = PH_RESET;
    int m_age   = 0;
    int m_run   = 0;
    int m_retry = 0;
    bit m_lost  = 0;
    bit m_terr  = 0;
    bit m_l1    = 0;
    bit m_l2    = 0;

    always #10 refclk = ~refclk;

    pll_reset_sequencer #(
        .RST_HOLD_CYCLES    (HOLD),
        .LOCK_STABLE_CYCLES (STABLE),
        .LOCK_TIMEOUT_CYCLES(TOUT),
        .NUM_DOMAINS        (ND),
        .DOMAIN_GAP_CYCLES  (GAP)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .restart_req (restart_req),
        .pll_rst     (pll_rst),
        .domain_rst  (domain_rst),
        .clocks_ready(clocks_ready),
        .lock_lost   (lock_lost),
        .timeout_err (timeout_err),
        .retry_count (retry_count)
    );

    // Model: phase plus cycles spent in it; lock seen two samples late.
    task automatic modelEdge();
        bit lk;
        int nxt;
        lk  = m_l2;
        nxt = -1;
        if (rst) begin
            m_phase = PH_RESET;
            m_age   = 0;
            m_run   = 0;
            m_lost  = 0;
            m_terr  = 0;
            m_retry = 0;
            m_l1    = 0;
            m_l2    = 0;
        end else begin
            m_terr = 0;
            case (m_phase)
                PH_RESET: if (m_age + 1 == HOLD) nxt = PH_WAIT;
                PH_WAIT: begin
                    m_run = lk ? m_run + 1 : 0;
                    if (m_run == STABLE) nxt = PH_REL;
                    else if (m_age + 1 == TOUT) begin
                        m_terr  = 1;
                        m_retry = (m_retry < 255) ? m_retry + 1 : 255;
                        nxt     = PH_RESET;
                    end
                    if (restart_req) nxt = PH_RESET;
                end
                PH_REL: begin
                    if (!lk) begin
                        m_lost = 1;
                        nxt    = PH_RESET;
                    end else if (m_age == (ND - 1) * GAP) nxt = PH_RUN;
                    if (restart_req) nxt = PH_RESET;
                end
                default: begin
                    if (!lk) begin
                        m_lost = 1;
                        nxt    = PH_RESET;
                    end
                    if (restart_req) nxt = PH_RESET;
                end
            endcase
            if (nxt >= 0) begin
                m_phase = nxt;
                m_age   = 0;
                m_run   = 0;
            end else begin
                m_age++;
            end
            m_l2 = m_l1;
            m_l1 = pll_locked;
        end
    endtask

    function automatic logic [ND-1:0] expDomain();
        logic [ND-1:0] d;
        for (int i = 0; i < ND; i++) begin
            d[i] = !(m_phase == PH_RUN || (m_phase == PH_REL && m_age >= i * GAP));
        end
        return d;
    endfunction

    task automatic expectEq(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) begin
            pass_checks++;
        end else begin
            $error("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", name, cyc, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        expectEq({tag, ".pll_rst"},      32'(pll_rst),      32'(m_phase == PH_RESET));
        expectEq({tag, ".domain_rst"},   32'(domain_rst),   32'(expDomain()));
        expectEq({tag, ".clocks_ready"}, 32'(clocks_ready), 32'(m_phase == PH_RUN));
        expectEq({tag, ".lock_lost"},    32'(lock_lost),    32'(m_lost));
        expectEq({tag, ".timeout_err"},  32'(timeout_err),  32'(m_terr));
        expectEq({tag, ".retry_count"},  32'(retry_count),  32'(m_retry));
    endtask

    task automatic applyStimulus(input logic r, input logic lk, input logic rq);
        rst         = r;
        pll_locked  = lk;
        restart_req = rq;
        @(posedge refclk);
        modelEdge();
        #1;
        cyc++;
        checkOutput("model");
    endtask

    task automatic resetBlock();
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        cyc = 0;
    endtask

    task automatic runUntil(input int target, input int lock_from, input int glitch_at);
        while (cyc < target) begin
            applyStimulus(1'b0, (cyc >= lock_from) && (cyc != glitch_at), 1'b0);
        end
    endtask

    initial begin
        bit found;
        $display("[TB] start");

        resetBlock();
        expectEq("reset.pll_rst",      32'(pll_rst),      32'd1);
        expectEq("reset.domain_rst",   32'(domain_rst),   32'h7);
        expectEq("reset.clocks_ready", 32'(clocks_ready), 32'd0);
        expectEq("reset.retry_count",  32'(retry_count),  32'd0);

        // Normal bring-up with lock from cycle 10.
        runUntil(3, 10, -1);
        expectEq("bringup.pll_rst_c3", 32'(pll_rst), 32'd1);
        runUntil(4, 10, -1);
        expectEq("bringup.pll_rst_c4", 32'(pll_rst), 32'd0);
        runUntil(19, 10, -1);
        expectEq("bringup.dom_c19", 32'(domain_rst), 32'h7);
        runUntil(20, 10, -1);
        expectEq("bringup.dom_c20", 32'(domain_rst), 32'h6);
        runUntil(22, 10, -1);
        expectEq("bringup.dom_c22", 32'(domain_rst), 32'h4);
        runUntil(24, 10, -1);
        expectEq("bringup.dom_c24", 32'(domain_rst), 32'h0);
        expectEq("bringup.ready_c24", 32'(clocks_ready), 32'd0);
        runUntil(25, 10, -1);
        expectEq("bringup.ready_c25", 32'(clocks_ready), 32'd1);
        runUntil(30, 10, -1);

        // Loss of lock in RUN at f = 30.
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        expectEq("loss.ready_f2", 32'(clocks_ready), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        expectEq("loss.dom_f3",   32'(domain_rst),   32'h7);
        expectEq("loss.ready_f3", 32'(clocks_ready), 32'd0);
        expectEq("loss.pllrst_f3", 32'(pll_rst),     32'd1);
        expectEq("loss.lost_f3",  32'(lock_lost),    32'd1);
        for (int k = 0; k < 40; k++) applyStimulus(1'b0, 1'b1, 1'b0);
        expectEq("loss.relock_ready", 32'(clocks_ready), 32'd1);
        expectEq("loss.relock_lost",  32'(lock_lost),    32'd1);

        // Lock glitch during qualification.
        resetBlock();
        runUntil(24, 10, 14);
        expectEq("glitch.dom_c24", 32'(domain_rst), 32'h7);
        runUntil(25, 10, 14);
        expectEq("glitch.dom_c25", 32'(domain_rst), 32'h6);
        runUntil(29, 10, 14);
        expectEq("glitch.ready_c29", 32'(clocks_ready), 32'd0);
        runUntil(30, 10, 14);
        expectEq("glitch.ready_c30", 32'(clocks_ready), 32'd1);
        expectEq("glitch.retry", 32'(retry_count), 32'd0);
        runUntil(31, 10, 14);

        // Reset mid-RUN.
        applyStimulus(1'b1, 1'b1, 1'b0);
        cyc = 0;
        expectEq("midrst.pll_rst", 32'(pll_rst),      32'd1);
        expectEq("midrst.dom",     32'(domain_rst),   32'h7);
        expectEq("midrst.ready",   32'(clocks_ready), 32'd0);
        runUntil(16, 0, -1);
        expectEq("midrst.ready_c16", 32'(clocks_ready), 32'd0);
        runUntil(17, 0, -1);
        expectEq("midrst.ready_c17", 32'(clocks_ready), 32'd1);

        // Timeouts until retry_count saturates.
        resetBlock();
        runUntil(103, 1 << 30, -1);
        expectEq("tout.terr_c103", 32'(timeout_err), 32'd0);
        runUntil(104, 1 << 30, -1);
        expectEq("tout.terr_c104",  32'(timeout_err), 32'd1);
        expectEq("tout.retry_c104", 32'(retry_count), 32'd1);
        expectEq("tout.pllrst_c104", 32'(pll_rst),    32'd1);
        runUntil(105, 1 << 30, -1);
        expectEq("tout.terr_c105", 32'(timeout_err), 32'd0);
        runUntil(104 * 258, 1 << 30, -1);
        expectEq("tout.retry_sat", 32'(retry_count), 32'd255);

        // Restart during RELEASE keeps retry_count and lock_lost.
        found = 0;
        for (int k = 0; k < 400 && !found; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            if (m_phase == PH_REL) found = 1;
        end
        expectEq("restart.reached_release", 32'(found), 32'd1);
        expectEq("restart.dom_before", 32'(domain_rst), 32'h6);
        applyStimulus(1'b0, 1'b1, 1'b1);
        expectEq("restart.dom_after",   32'(domain_rst), 32'h7);
        expectEq("restart.pllrst_after", 32'(pll_rst),   32'd1);
        for (int k = 0; k < 40; k++) applyStimulus(1'b0, 1'b1, 1'b0);
        expectEq("restart.ready", 32'(clocks_ready), 32'd1);
        expectEq("restart.retry", 32'(retry_count),  32'd255);
        expectEq("restart.lost",  32'(lock_lost),    32'd0);

        // Random lock drops, restarts and occasional block resets.
        begin
            logic lk;
            lk = 1'b1;
            for (int k = 0; k < 4000; k++) begin
                if ($urandom_range(0, 39) == 0) lk = ~lk;
                applyStimulus($urandom_range(0, 799) == 0, lk, $urandom_range(0, 99) == 0);
            end
        end

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Controls reset and bring-up of the system PLL that generates the 126 / 25.2 / 12.6 MHz clocks from the 50 MHz reference. The block runs on the reference clock and holds the PLL in reset for a fixed time. It then waits for a stable lock and releases the per-clock-domain resets in a fixed order, so downstream logic only leaves reset on a clean clock. Loss of lock, lock timeout, or a software restart request re-runs the sequence. The block sits beside the PLL wrapper in the top level and drives its `rst` input.

## Interface

Parameters:
- `RST_HOLD_CYCLES`, 10: refclk cycles `pll_rst` stays high per attempt (≥1).
- `LOCK_STABLE_CYCLES`, 256: consecutive synchronized-lock-high cycles required (≥1).
- `LOCK_TIMEOUT_CYCLES`, 50000: max cycles in WAIT_LOCK before retry (> LOCK_STABLE_CYCLES).
- `NUM_DOMAINS`, 3: number of downstream domain resets (≥1).
- `DOMAIN_GAP_CYCLES`, 16: cycles between successive domain releases (≥1).

Ports:
- `refclk` in 1: 50 MHz reference; the only clock.
- `rst` in 1: synchronous, active-high block reset.
- `pll_locked` in 1: PLL lock, asynchronous to `refclk`.
- `restart_req` in 1: single-cycle request to re-run the sequence.
- `pll_rst` out 1: PLL reset, active-high.
- `domain_rst` out NUM_DOMAINS: per-domain reset, active-high; bit 0 released first.
- `clocks_ready` out 1: high only in RUN.
- `lock_lost` out 1: sticky flag; lock dropped after it was qualified.
- `timeout_err` out 1: one-cycle pulse when a lock timeout occurs.
- `retry_count` out 8: count of timeouts, saturates at 255.

## Operation

- **Clocking and reset.** One clock (`refclk`). Reset `rst` is synchronous and active-high.
- **Reset values (rst high).**
  - State = RESET, all counters = 0.
  - `pll_rst`=1, `domain_rst`=all 1s, `clocks_ready`=0, `lock_lost`=0, `timeout_err`=0, `retry_count`=0.
- **Lock synchronizer.** `pll_locked` passes through a 2-flop synchronizer (reset to 0) giving `lk_s`. Only `lk_s` is used internally.
- **Outputs.** All outputs are registered and update on the same edge as the state register. Each output's value is a function of the state being entered.
- **RESET state.**
  - `pll_rst`=1, all `domain_rst`=1.
  - Hold counter counts 0..RST_HOLD_CYCLES-1, then the block enters WAIT_LOCK.
  - `pll_rst` is therefore high for exactly RST_HOLD_CYCLES cycles per entry.
- **WAIT_LOCK state.**
  - `pll_rst`=0, all `domain_rst`=1.
  - Stable counter: increments while `lk_s`=1 and clears to 0 when `lk_s`=0.
  - When the stable counter reaches LOCK_STABLE_CYCLES, the block enters RELEASE.
  - Timeout counter increments every cycle. When it reaches LOCK_TIMEOUT_CYCLES, the block enters RESET, pulses `timeout_err`, and increments `retry_count` (saturating).
  - If stable and timeout are reached in the same cycle, stable wins.
- **RELEASE state.**
  - `domain_rst[i]` deasserts on RELEASE cycle i×DOMAIN_GAP_CYCLES (cycle 0 = first RELEASE cycle).
  - Once deasserted, a bit stays low.
  - After the last bit is released, the next cycle enters RUN.
- **RUN state.** `clocks_ready`=1, `pll_rst`=0, all `domain_rst`=0.
- **Lock loss.**
  - Trigger: `lk_s`=0 while in RELEASE or RUN.
  - Action: enter RESET; all `domain_rst`=1, `clocks_ready`=0, `pll_rst`=1 on that same edge; `lock_lost` is set.
  - `lock_lost` clears only on `rst`.
- **Restart request.**
  - `restart_req`=1 in WAIT_LOCK, RELEASE or RUN: enter RESET; counters clear.
  - `lock_lost` and `retry_count` are not changed by a restart.
  - `restart_req` in RESET is ignored; the hold counter is not restarted.
- **Simultaneous events.**
  - Lock loss together with `restart_req`: enter RESET and set `lock_lost`.
  - Timeout together with `restart_req`: enter RESET, pulse `timeout_err`, and increment `retry_count`.
- **`rst` mid-operation.** Forces reset values on the next edge, regardless of state.
- **Counter widths.** Each counter is `$clog2` of its bound plus 1 bit. No counter wraps; each is cleared on every state entry.

## Timing

- Let r be the first cycle in which `pll_locked` is sampled high (in WAIT_LOCK, lock held).
  - `lk_s` is high from r+2.
  - RELEASE is entered at r+2+LOCK_STABLE_CYCLES.
- `domain_rst[i]` falls at r+2+LOCK_STABLE_CYCLES+i×DOMAIN_GAP_CYCLES.
- `clocks_ready` rises (NUM_DOMAINS-1)×DOMAIN_GAP_CYCLES+1 cycles after RELEASE entry.
- Lock loss: `pll_locked` falling at cycle f asserts all `domain_rst`, and drops `clocks_ready`, from cycle f+3.
- `restart_req` sampled high at cycle t produces the RESET outputs from cycle t+1.

## Test plan

All scenarios use RST_HOLD=4, LOCK_STABLE=8, LOCK_TIMEOUT=100, NUM_DOMAINS=3, DOMAIN_GAP=2.

- **Normal bring-up.** `rst` low from cycle 0; `pll_locked`=1 from cycle 10 → `pll_rst` high cycles 0–3; `domain_rst[0]` falls at 20, [1] at 22, [2] at 24; `clocks_ready`=1 from 25.
- **Lock glitch during qualification.** `pll_locked` low for one cycle at 14 → stable count restarts; release is delayed accordingly; no `timeout_err`.
- **Timeout.** `pll_locked` held 0 → `timeout_err` pulses after 100 WAIT_LOCK cycles; `retry_count`=1; `pll_rst` high for 4 cycles; repeats until `retry_count`=255, then saturates.
- **Loss of lock in RUN.** `pll_locked` drops at f → `domain_rst`=3'b111, `clocks_ready`=0 and `pll_rst`=1 at f+3; `lock_lost`=1 and stays 1 through a successful re-lock.
- **Restart in RELEASE.** `restart_req` pulsed while `domain_rst`=3'b110 → all 1s next cycle; a full sequence follows; `lock_lost`=0 and `retry_count` unchanged.
- **Reset mid-RUN.** `rst` for one cycle → all reset values next cycle; the sequence restarts from RESET.
